elevator_ctrl_scan: RTL and testbench

Parametrised successor to the single-request elevator controller. It supports a configurable number of floors and keeps a pending-request bitmap, so multiple calls can be queued. Calls are served in SCAN (elevator) order: it continues in the current direction while calls remain ahead, then reverses. It models per-floor travel time and a timed door-open phase, and rejects requests to floors that do not exist. It sits between the floor-call input logic and the floor display / motor-drive logic.

---
 rtl/elevator_ctrl_scan_if.sv | 28 ++
 rtl/elevator_ctrl_scan.sv | 151 +++++++++++++++
 tb/tb_elevator_ctrl_scan.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_ctrl_scan_if.sv
// Call/status bundle between floor-call logic and the elevator controller.
// The master drives calls and door hold; the slave reports car status.
interface elevator_ctrl_scan_if #(
  parameter int NUM_FLOORS = 51,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
);
  logic                  req_valid;
  logic [FLOOR_W-1:0]    req_floor;
  logic                  door_hold;
  logic [FLOOR_W-1:0]    elevator_floor;
  logic                  moving;
  logic                  dir_up;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic                  req_err;

  modport master (
    output req_valid, req_floor, door_hold,
    input  elevator_floor, moving, dir_up,
    input  door_open, pending, req_err
  );

  modport slave (
    input  req_valid, req_floor, door_hold,
    output elevator_floor, moving, dir_up,
    output door_open, pending, req_err
  );
endinterface

// File: rtl/elevator_ctrl_scan.sv
// SCAN-order elevator controller with a pending-call bitmap,
// per-floor travel time and a timed, holdable door phase.
module elevator_ctrl_scan #(
  parameter int NUM_FLOORS    = 51,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  elevator_ctrl_scan_if.slave  bus
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DOOR
  } state_e;

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  dir_q, dir_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic                  err_q;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [DW-1:0]         dcnt_q, dcnt_d;

  logic                  bad, same, setb;
  logic                  step, hit, ahead, behind;
  logic [FLOOR_W-1:0]    step_floor;
  logic [NUM_FLOORS-1:0] set_mask, step_hot;
  logic [NUM_FLOORS-1:0] above, below;

  assign bad  = bus.req_valid &&
                (int'(bus.req_floor) >= NUM_FLOORS);
  assign same = bus.req_valid && !bad &&
                (bus.req_floor == floor_q) &&
                (state_q != S_MOVE);
  assign setb = bus.req_valid && !bad && !same;

  assign step = (state_q == S_MOVE) &&
                (tcnt_q == TW'(TRAVEL_CYCLES - 1));
  assign step_floor = dir_q ? floor_q + FLOOR_W'(1)
                            : floor_q - FLOOR_W'(1);

  always_comb begin
    set_mask = '0;
    step_hot = '0;
    above    = '0;
    below    = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      set_mask[i] = setb && (bus.req_floor == FLOOR_W'(i));
      step_hot[i] = (step_floor == FLOOR_W'(i));
      above[i]    = pend_q[i] && (FLOOR_W'(i) > floor_q);
      below[i]    = pend_q[i] && (FLOOR_W'(i) < floor_q);
    end
  end

  assign hit    = step && |(pend_q & step_hot);
  assign ahead  = dir_q ? |above : |below;
  assign behind = dir_q ? |below : |above;

  // Arrival clear is applied after the new call so clear wins.
  assign pend_d = (pend_q | set_mask) &
                  ~(hit ? step_hot : '0);

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (same) begin
          state_d = S_DOOR;
          dcnt_d  = '0;
        end else if (ahead) begin
          state_d = S_MOVE;
          tcnt_d  = '0;
        end else if (behind) begin
          state_d = S_MOVE;
          dir_d   = !dir_q;
          tcnt_d  = '0;
        end
      end
      S_MOVE: begin
        if (step) begin
          floor_d = step_floor;
          tcnt_d  = '0;
          if (hit) begin
            state_d = S_DOOR;
            dcnt_d  = '0;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DOOR: begin
        if (bus.door_hold || same) begin
          dcnt_d = '0;
        end else if (dcnt_q == DW'(DOOR_CYCLES - 1)) begin
          if (ahead) begin
            state_d = S_MOVE;
            tcnt_d  = '0;
          end else if (behind) begin
            state_d = S_MOVE;
            dir_d   = !dir_q;
            tcnt_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      floor_q <= '0;
      dir_q   <= 1'b1;
      pend_q  <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      err_q   <= bad;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign bus.elevator_floor = floor_q;
  assign bus.moving         = (state_q == S_MOVE);
  assign bus.dir_up         = dir_q;
  assign bus.door_open      = (state_q == S_DOOR);
  assign bus.pending        = pend_q;
  assign bus.req_err        = err_q;

endmodule

// File: tb/tb_elevator_ctrl_scan.sv
// Bench for elevator_ctrl_scan: countdown-based car model,
// per-cycle output compare, directed scenarios plus random calls.
module tb_elevator_ctrl_scan;

  localparam int NF = 51;
  localparam int FW = 6;
  localparam int TC = 4;
  localparam int DC = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  elevator_ctrl_scan_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

  elevator_ctrl_scan #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES  (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(string name, logic [63:0] got,
                       logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Reference car: remaining-cycle countdowns and a call set.
  int          m_floor;
  bit          m_up, m_mv, m_dr, m_err;
  logic [NF-1:0] m_p, np;
  int          m_tl, m_dl, rf;
  bit          bad, same, setb, ah, bh;

  function automatic bit calls_above();
    for (int i = m_floor + 1; i < NF; i++)
      if (m_p[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit calls_below();
    for (int i = 0; i < m_floor; i++)
      if (m_p[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_floor = 0; m_up = 1; m_mv = 0; m_dr = 0;
      m_err = 0; m_p = '0; m_tl = 0; m_dl = 0;
    end else begin
      rf   = int'(bus.req_floor);
      bad  = bus.req_valid && rf >= NF;
      same = bus.req_valid && !bad && rf == m_floor && !m_mv;
      setb = bus.req_valid && !bad && !same;
      ah   = m_up ? calls_above() : calls_below();
      bh   = m_up ? calls_below() : calls_above();
      np   = m_p;
      if (setb) np[rf] = 1'b1;
      m_err = bad;
      if (m_mv) begin
        m_tl--;
        if (m_tl == 0) begin
          m_floor += m_up ? 1 : -1;
          m_tl = TC;
          if (m_p[m_floor]) begin
            np[m_floor] = 1'b0;
            m_mv = 0; m_dr = 1; m_dl = DC;
          end
        end
      end else if (m_dr) begin
        if (bus.door_hold || same) m_dl = DC;
        else begin
          m_dl--;
          if (m_dl == 0) begin
            m_dr = 0;
            if (ah) begin
              m_mv = 1; m_tl = TC;
            end else if (bh) begin
              m_up = !m_up; m_mv = 1; m_tl = TC;
            end
          end
        end
      end else begin
        if (same) begin
          m_dr = 1; m_dl = DC;
        end else if (ah) begin
          m_mv = 1; m_tl = TC;
        end else if (bh) begin
          m_up = !m_up; m_mv = 1; m_tl = TC;
        end
      end
      m_p = np;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("floor",   bus.elevator_floor, m_floor);
      check("moving",  bus.moving,         m_mv);
      check("dir_up",  bus.dir_up,         m_up);
      check("door",    bus.door_open,      m_dr);
      check("pending", bus.pending,        m_p);
      check("req_err", bus.req_err,        m_err);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(int f);
    bus.req_valid = 1'b1;
    bus.req_floor = f[5:0];
    tick();
    bus.req_valid = 1'b0;
  endtask

  function automatic bit cond(int sel, int arg);
    case (sel)
      0:       return bus.door_open;
      1:       return !bus.door_open;
      default: return int'(bus.elevator_floor) == arg;
    endcase
  endfunction

  task automatic wait_for(string name, int sel, int arg,
                          int maxc, output int n);
    n = 0;
    while (!cond(sel, arg)) begin
      if (n >= maxc) begin
        check({name, "_timeout"}, 64'd0, 64'd1);
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int n;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_floor = '0;
    bus.door_hold = 1'b0;
    tick(2);
    reset = 1'b0;
    check("rst_floor",   bus.elevator_floor, 0);
    check("rst_dir",     bus.dir_up,         1);
    check("rst_pending", bus.pending,        0);
    check("rst_moving",  bus.moving,         0);

    // Single call to 30 from floor 0
    req(30);
    check("s1_pend30", bus.pending, 64'd1 << 30);
    tick();
    check("s1_moving", bus.moving, 1);
    check("s1_dir",    bus.dir_up, 1);
    wait_for("s1_arrive", 0, 0, 400, n);
    check("s1_travel", n, 120);
    check("s1_floor",  bus.elevator_floor, 30);
    wait_for("s1_door", 1, 0, 50, n);
    check("s1_doorlen", n, 8);
    check("s1_idle",    bus.moving, 0);
    check("s1_empty",   bus.pending, 0);

    // Calls both sides of 30: ahead first, then reverse
    req(44);
    req(10);
    wait_for("s3_a", 0, 0, 200, n);
    check("s3_floor44", bus.elevator_floor, 44);
    check("s3_dir_up",  bus.dir_up, 1);
    wait_for("s3_b", 1, 0, 50, n);
    check("s3_rev_mv",  bus.moving, 1);
    check("s3_rev_dir", bus.dir_up, 0);
    wait_for("s3_c", 0, 0, 400, n);
    check("s3_floor10", bus.elevator_floor, 10);
    wait_for("s3_d", 1, 0, 50, n);

    // Nonexistent floor, then the top floor
    req(55);
    check("s2_err",     bus.req_err, 1);
    check("s2_pend",    bus.pending, 0);
    tick();
    check("s2_err_off", bus.req_err, 0);
    req(50);
    check("s2_pend50",  bus.pending, 64'd1 << 50);
    wait_for("s2_a", 0, 0, 400, n);
    check("s2_floor50", bus.elevator_floor, 50);
    wait_for("s2_b", 1, 0, 50, n);

    // Pick-up on the way
    do_reset();
    req(30);
    wait_for("s4_a", 2, 5, 100, n);
    req(20);
    wait_for("s4_b", 0, 0, 200, n);
    check("s4_floor20", bus.elevator_floor, 20);
    check("s4_pending", bus.pending, 64'd1 << 30);
    wait_for("s4_c", 1, 0, 50, n);
    wait_for("s4_d", 0, 0, 200, n);
    check("s4_floor30", bus.elevator_floor, 30);
    wait_for("s4_e", 1, 0, 50, n);

    // Door hold, then async reset mid-move
    do_reset();
    req(12);
    wait_for("s5_a", 0, 0, 200, n);
    bus.door_hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("s5_held", bus.door_open, 1);
    end
    bus.door_hold = 1'b0;
    wait_for("s5_b", 1, 0, 50, n);
    check("s5_doorlen", n, 8);
    req(25);
    tick(10);
    #2 reset = 1'b1;
    #1;
    check("s5_rst_floor", bus.elevator_floor, 0);
    check("s5_rst_pend",  bus.pending, 0);
    check("s5_rst_mv",    bus.moving, 0);
    check("s5_rst_door",  bus.door_open, 0);
    tick();
    reset = 1'b0;

    // Same-floor call while idle
    req(0);
    check("s6_door", bus.door_open, 1);
    check("s6_mv",   bus.moving, 0);
    check("s6_pend", bus.pending, 0);
    wait_for("s6_a", 1, 0, 50, n);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bus.req_valid = ($urandom % 4) == 0;
      bus.req_floor = 6'($urandom % 64);
      bus.door_hold = ($urandom % 16) == 0;
      tick();
    end
    bus.req_valid = 1'b0;
    bus.door_hold = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
